// File: rtl/partial_rank_accumulator_pkg.sv
// rank_pkg: shared defaults and state encoding for the partial rank accumulator
package rank_pkg;
    localparam int DEF_NUM_LANES = 10;
    localparam int DEF_DATA_W = 32;
    localparam logic [DEF_DATA_W-1:0] SAT_MAX = '1;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
endpackage

// File: rtl/partial_rank_accumulator_rr_arbiter.sv
// rr_arbiter: combinational pick of the first request at or after rr_ptr, wrapping
module rr_arbiter #(
    parameter int NUM_LANES = 10,
    parameter int PTR_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [PTR_W-1:0]     idx
);
    logic found;
    logic [PTR_W-1:0] j;
    always_comb begin
        found = 1'b0;
        idx = '0;
        j = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            j = PTR_W'((int'(rr_ptr) + k) % NUM_LANES);
            if (!found && req[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
        grant = found ? NUM_LANES'(1) << idx : '0;
    end
endmodule

// File: rtl/partial_rank_accumulator.sv
// partial_rank_accumulator: drains divider lanes round-robin and sums a job's partial ranks
module partial_rank_accumulator
    import rank_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [IDX_W-1:0]            first_index,
    input  logic [IDX_W-1:0]            last_index,
    input  logic [NUM_LANES-1:0]        lane_valid,
    input  logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic [NUM_LANES-1:0]        lane_ack,
    output logic [DATA_W-1:0]           sum_out,
    output logic                        sum_valid,
    output logic                        busy,
    output logic                        overflow
);
    localparam int PTR_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    state_t state, state_n;
    logic [PTR_W-1:0] rr_ptr, g;
    logic [IDX_W-1:0] count, expected;
    logic [NUM_LANES-1:0] grant;
    logic [DATA_W-1:0] lane_word [NUM_LANES];
    logic [DATA_W:0] sum_ext;
    logic accept;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_unpack
        assign lane_word[i] = lane_data[i*DATA_W +: DATA_W];
    end
    rr_arbiter #(.NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_arb (
        .req   (lane_valid),
        .rr_ptr(rr_ptr),
        .grant (grant),
        .idx   (g)
    );
    assign accept = state == COLLECT && |grant && count < expected;
    assign lane_ack = accept ? grant : '0;
    assign sum_ext = {1'b0, sum_out} + {1'b0, lane_word[g]};
    assign sum_valid = state == DONE;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? (last_index > first_index ? COLLECT : DONE) : IDLE)
                : state == COLLECT ? (accept && count + IDX_W'(1) == expected ? DONE : COLLECT)
                : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            count <= '0;
            expected <= '0;
            sum_out <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                expected <= last_index > first_index ? last_index - first_index : '0;
                count <= '0;
                sum_out <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                // carry out of the widened add means the sum clipped
                sum_out <= sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
                overflow <= overflow | sum_ext[DATA_W];
                count <= count + IDX_W'(1);
                rr_ptr <= g == PTR_W'(NUM_LANES - 1) ? '0 : g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_partial_rank_accumulator.sv
// tb_partial_rank_accumulator: vector table, corner sequences and random traffic vs a reference model
module tb_partial_rank_accumulator;
    localparam int N = 10;
    localparam int DW = 32;
    localparam int IW = 32;
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0;
    logic [IW-1:0] first_index = '0, last_index = '0;
    logic [N-1:0] lane_valid = '0;
    logic [N*DW-1:0] lane_data = '0;
    logic [N-1:0] lane_ack;
    logic [DW-1:0] sum_out;
    logic sum_valid, busy, overflow;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    partial_rank_accumulator #(.NUM_LANES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .first_index(first_index),
        .last_index(last_index), .lane_valid(lane_valid), .lane_data(lane_data),
        .lane_ack(lane_ack), .sum_out(sum_out), .sum_valid(sum_valid),
        .busy(busy), .overflow(overflow)
    );
    // reference: phase 0 idle, 1 collecting, 2 reporting; rem = contributions still owed
    int m_phase = 0, m_ptr = 0, m_g;
    longint m_rem = 0, m_sum = 0;
    bit m_ovf = 0;
    logic [N-1:0] last_ack;
    logic last_sv, last_busy, last_ovf;
    logic [DW-1:0] last_sum;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int pick();
        if (m_phase != 1 || m_rem == 0) return -1;
        for (int k = 0; k < N; k++)
            if (lane_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction
    task automatic tick();
        @(negedge clk);
        m_g = pick();
        chk("lane_ack", 64'(lane_ack), m_g < 0 ? 64'd0 : 64'd1 << m_g);
        chk("sum_out", 64'(sum_out), 64'(m_sum));
        chk("sum_valid", 64'(sum_valid), 64'(m_phase == 2));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        last_ack = lane_ack; last_sv = sum_valid; last_busy = busy;
        last_sum = sum_out; last_ovf = overflow;
        @(posedge clk);
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_rem = 0; m_sum = 0; m_ovf = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_sum = 0; m_ovf = 0;
                m_rem = last_index > first_index ? longint'(last_index) - longint'(first_index) : 0;
                m_phase = m_rem > 0 ? 1 : 2;
            end
        end else if (m_phase == 1) begin
            if (m_g >= 0) begin
                m_sum += longint'(lane_data[m_g*DW +: DW]);
                if (m_sum > 64'hFFFF_FFFF) begin m_sum = 64'hFFFF_FFFF; m_ovf = 1; end
                m_rem--;
                m_ptr = (m_g + 1) % N;
                if (m_rem == 0) m_phase = 2;
            end
        end else m_phase = 0;
        #1;
    endtask
    task automatic fill(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < N; i++) lane_data[i*DW +: DW] = base + 32'(i) * step;
    endtask
    task automatic launch(input logic [31:0] f, input logic [31:0] l);
        first_index = f; last_index = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    typedef struct {
        string nm;
        logic [31:0] first, last;
        logic [N-1:0] mask;
        logic [31:0] base, step, exp_sum;
        logic exp_ovf;
        int exp_lat, exp_acks;
    } vec_t;
    vec_t vecs [7];
    initial begin
        int lat, acks, pulses;
        // lane i carries base + i*step (32-bit wrap); step 0x30000000 puts 0x20000000 on lane 1
        vecs[0] = '{"basic",    0, 10, 10'h3FF, 1, 1, 55, 0, 11, 10};
        vecs[1] = '{"empty",    7, 7, 10'h3FF, 1, 1, 0, 0, 1, 0};
        vecs[2] = '{"extras",   0, 2, 10'h00F, 100, 0, 200, 0, 3, 2};
        vecs[3] = '{"saturate", 0, 2, 10'h003, 32'hF000_0000, 32'h3000_0000, 32'hFFFF_FFFF, 1, 3, 2};
        vecs[4] = '{"ovf_clear", 0, 1, 10'h020, 7, 0, 7, 0, 2, 1};
        vecs[5] = '{"inverted", 9, 3, 10'h3FF, 1, 1, 0, 0, 1, 0};
        vecs[6] = '{"alternate", 100, 104, 10'h201, 5, 5, 110, 0, 5, 4};
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        tick();
        foreach (vecs[v]) begin
            fill(vecs[v].base, vecs[v].step);
            lane_valid = vecs[v].mask;
            launch(vecs[v].first, vecs[v].last);
            lat = 0; acks = 0;
            for (int c = 1; c <= 40 && lat == 0; c++) begin
                tick();
                acks += $countones(last_ack);
                if (last_sv) lat = c;
            end
            chk({vecs[v].nm, " done"}, 64'(last_sv), 64'd1);
            chk({vecs[v].nm, " latency"}, 64'(lat), 64'(vecs[v].exp_lat));
            chk({vecs[v].nm, " acks"}, 64'(acks), 64'(vecs[v].exp_acks));
            chk({vecs[v].nm, " sum"}, 64'(last_sum), 64'(vecs[v].exp_sum));
            chk({vecs[v].nm, " ovf"}, 64'(last_ovf), 64'(vecs[v].exp_ovf));
            lane_valid = '0;
            tick();
            chk({vecs[v].nm, " busy after"}, 64'(last_busy), 64'd0);
            chk({vecs[v].nm, " sum held"}, 64'(last_sum), 64'(vecs[v].exp_sum));
        end
        // round-robin: leave pointer at 3, then lanes 1 and 7 contend
        reset = 1'b1; tick(); reset = 1'b0;
        fill(1, 0); lane_valid = '1;
        launch(0, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr warmup ack", 64'(last_ack), 64'd1 << i);
        end
        tick();
        lane_valid = 10'h082;
        launch(0, 2);
        tick(); chk("rr first lane7", 64'(last_ack), 64'h080);
        tick(); chk("rr then lane1", 64'(last_ack), 64'h002);
        tick();
        lane_valid = 10'h005;
        launch(0, 1);
        tick(); chk("rr ptr at 2", 64'(last_ack), 64'h004);
        tick();
        // sparse producer on lane 4
        lane_valid = '0; fill(32'h10, 0);
        launch(5, 8);
        acks = 0; pulses = 0;
        for (int c = 1; c <= 14; c++) begin
            lane_valid = (c == 2 || c == 6 || c == 9) ? 10'h010 : '0;
            tick();
            acks += $countones(last_ack);
            pulses += int'(last_sv);
            if (c == 10) begin
                chk("sparse sum_valid", 64'(last_sv), 64'd1);
                chk("sparse sum", 64'(last_sum), 64'h30);
            end
        end
        chk("sparse acks", 64'(acks), 64'd3);
        chk("sparse pulses", 64'(pulses), 64'd1);
        // start while collecting is ignored
        lane_valid = '0; fill(1, 0);
        launch(0, 2);
        tick(); tick();
        first_index = 0; last_index = 9; start = 1'b1;
        tick();
        start = 1'b0; lane_valid = '1;
        lat = 0; acks = 0;
        for (int c = 0; c < 20 && lat == 0; c++) begin
            tick();
            acks += $countones(last_ack);
            if (last_sv) lat = 1;
        end
        chk("busy start done", 64'(last_sv), 64'd1);
        chk("busy start sum", 64'(last_sum), 64'd2);
        chk("busy start acks", 64'(acks), 64'd2);
        lane_valid = '0; tick();
        // reset after three accepts aborts the job
        lane_valid = '1;
        launch(0, 6);
        tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        chk("abort busy", 64'(last_busy), 64'd0);
        chk("abort sum", 64'(last_sum), 64'd0);
        chk("abort ack", 64'(last_ack), 64'd0);
        pulses = int'(last_sv);
        for (int c = 0; c < 8; c++) begin tick(); pulses += int'(last_sv); end
        chk("abort no sum_valid", 64'(pulses), 64'd0);
        // random traffic
        for (int c = 0; c < 600; c++) begin
            reset = $urandom_range(0, 99) == 0;
            start = $urandom_range(0, 5) == 0;
            first_index = $urandom_range(0, 20);
            last_index = $urandom_range(0, 26);
            lane_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                lane_data[i*DW +: DW] = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 1000);
            tick();
        end
        reset = 1'b0; start = 1'b0; lane_valid = '0;
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/partial_rank_accumulator.md
Name: partial_rank_accumulator

Overview:
- Consumer end of the parallel-division lane interface. Drains per-lane partial PageRank results (PR/outdeg quotients) from NUM_LANES divider lanes under a valid/ack handshake, using a round-robin order.
- Sums exactly (last_index - first_index) contributions into one accumulated rank value and reports it with a single-cycle valid pulse.
- Sits between the divider bank and the rank write-back/BRAM update logic.

Parameters:
- NUM_LANES, 10, number of divider lanes drained.
- DATA_W, 32, width of each partial rank and of the sum (unsigned fixed-point).
- IDX_W, 32, width of first_index/last_index and of the internal contribution counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches indices and begins a collection job (honoured only in IDLE).
- first_index  in  IDX_W  first vertex index of the job.
- last_index  in  IDX_W  one past last vertex index; expected contribution count = last_index - first_index.
- lane_valid  in  NUM_LANES  bit i: lane i holds a valid partial rank.
- lane_data  in  NUM_LANES*DATA_W  flattened lane results; lane i occupies bits [i*DATA_W +: DATA_W].
- lane_ack  out  NUM_LANES  one-hot grant; bit i high means lane i's data is consumed at this clock edge.
- sum_out  out  DATA_W  accumulated sum; held stable after the job completes.
- sum_valid  out  1  one-cycle pulse when sum_out is final.
- busy  out  1  high while in COLLECT or DONE.
- overflow  out  1  sticky per job; set when a saturating add clipped.

Behaviour:
- Reset values: sum_out=0, sum_valid=0, busy=0, overflow=0, lane_ack=0. Internally: state=IDLE, rr_ptr=0, count=0, expected=0.
- FSM states are IDLE, COLLECT and DONE.
- IDLE:
  - On start, latch expected = last_index - first_index (unsigned), clear sum_out, overflow and count, and go to COLLECT.
  - If last_index <= first_index, set expected=0 and go directly to DONE; the job completes with sum 0.
  - start outside IDLE is ignored, with no effect on the job in progress.
- COLLECT:
  - Each cycle, search lane_valid for the first set bit starting at rr_ptr and wrapping modulo NUM_LANES. Call it g.
  - If a valid lane is found and count < expected:
    - lane_ack = one-hot(g), combinational from the current state and inputs.
    - At the edge: sum_out <= sat_add(sum_out, lane_data[g]), count++, rr_ptr <= (g+1) mod NUM_LANES.
  - If no lane is valid, lane_ack=0 and there is no state change.
  - At most one lane is accepted per cycle.
  - A producer must drop valid, or present new data, in the cycle after its ack.
  - When the accepting edge makes count == expected, go to DONE.
- DONE: sum_valid=1 for exactly one cycle, lane_ack=0, next state IDLE. busy is still high in DONE and low in the following IDLE cycle.
- Latency: sum_valid is asserted 1 cycle after the final accepting edge. With all lanes valid continuously, a job of N contributions takes N+1 cycles after start.
- Arithmetic:
  - Unsigned, DATA_W-bit adds, computed with a DATA_W+1 intermediate.
  - If the carry is set, sum_out saturates to all ones and overflow is set.
  - Once set, overflow stays set until the next start.
- Extra valids: lanes still valid after count == expected are never acked.
- Simultaneous valids: the lowest index at or after rr_ptr wins. The others wait, with a guaranteed grant within NUM_LANES accepts.
- Reset mid-job: the job is aborted and all state returns to reset values the next cycle. No sum_valid is produced for the aborted job.
- sum_out holds its final value in IDLE until the next accepted start.

Decomposition:
- Shared package (rank_pkg):
  - NUM_LANES and DATA_W defaults.
  - State encoding typedef: IDLE, COLLECT, DONE.
  - SAT_MAX constant (all ones of DATA_W).
- One natural sub-module: rr_arbiter. Parameterised by NUM_LANES; inputs req vector and rr_ptr; outputs one-hot grant and an encoded index. It is purely combinational. The pointer update stays in the parent.

Test Plan:
- Basic: first=0, last=10, all 10 lanes valid with data i+1 -> acks lanes 0..9 in order over 10 cycles; sum_out=55; sum_valid pulses once on cycle 11 after start; overflow=0.
- Round-robin fairness: rr_ptr=3 after a prior job; lanes 1 and 7 valid together -> lane 7 acked first, then lane 1. Next rr_ptr is 2.
- Sparse/bursty: first=5, last=8, lane 4 valid with 0x10 on cycles 2, 6 and 9 only -> exactly 3 acks; sum_out=0x30; sum_valid the cycle after the third ack. lane_ack stays 0 on idle cycles.
- Empty job and extras: first=7, last=7 -> sum_valid one cycle after start with sum_out=0, no acks. Then first=0, last=2 with 4 lanes valid -> only 2 acks; the remaining lanes stay un-acked.
- Saturation: DATA_W=32; lanes carry 0xF0000000 and 0x20000000 -> sum_out=0xFFFFFFFF, overflow=1. A following start clears overflow to 0.
- Reset and start-while-busy:
  - start pulsed during COLLECT -> ignored.
  - reset asserted mid-job after 3 accepts -> next cycle busy=0, sum_out=0, lane_ack=0, and no sum_valid.
